sparse_expander: RTL and testbench

Streaming decompressor for the sparse datapath. It accepts one bitmask per block and a stream of dense beats holding the non-zero elements in mask order. It scatters those elements back into their bit positions and emits one full-width sparse vector with zeros in the masked-off slots. It is the inverse of the bitmask-driven input filter/compactor and sits on the consumer side of compressed activation/weight streams.

---
 rtl/sparse_expander_pkg.sv | 16 +
 rtl/sparse_expander_mask_prefix_counter.sv | 26 ++
 rtl/sparse_expander.sv | 145 ++++++++++++++
 tb/tb_sparse_expander.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sparse_expander_pkg.sv
// Shared FSM encoding and default widths for the sparse expander.
package sparse_expander_pkg;

   localparam int unsigned DEF_BITMASK_LENGTH     = 16;
   localparam int unsigned DEF_ELEMENT_WIDTH      = 8;
   localparam int unsigned DEF_NUM_DENSE_PER_BEAT = 4;
   localparam int unsigned DEF_COUNT_BITWIDTH     = $clog2(DEF_NUM_DENSE_PER_BEAT + 1);
   localparam int unsigned DEF_INDEX_BITWIDTH     = $clog2(DEF_BITMASK_LENGTH + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
      OUTPUT = 2'd2
   } state_e;

endpackage

// File: rtl/sparse_expander_mask_prefix_counter.sv
// Combinational exclusive prefix count of a mask: rank of every position plus total popcount.
module mask_prefix_counter
   import sparse_expander_pkg::*;
#(
   parameter int unsigned BITMASK_LENGTH = DEF_BITMASK_LENGTH,
   parameter int unsigned INDEX_BITWIDTH = DEF_INDEX_BITWIDTH
) (
   input  logic [BITMASK_LENGTH-1:0]                mask,
   output logic [BITMASK_LENGTH*INDEX_BITWIDTH-1:0] rank_c,
   output logic [INDEX_BITWIDTH-1:0]                popcount_c
);

   logic [INDEX_BITWIDTH-1:0] acc;

   // Running count of ones strictly below each position
   always_comb begin
      acc    = '0;
      rank_c = '0;
      for (int p = 0; p < int'(BITMASK_LENGTH); p++) begin
         rank_c[p*INDEX_BITWIDTH +: INDEX_BITWIDTH] = acc;
         acc = acc + INDEX_BITWIDTH'(mask[p]);
      end
      popcount_c = acc;
   end

endmodule

// File: rtl/sparse_expander.sv
// Scatters a stream of dense beats back into the mask positions of a full-width sparse vector.
module sparse_expander
   import sparse_expander_pkg::*;
#(
   parameter int unsigned BITMASK_LENGTH     = DEF_BITMASK_LENGTH,
   parameter int unsigned ELEMENT_WIDTH      = DEF_ELEMENT_WIDTH,
   parameter int unsigned NUM_DENSE_PER_BEAT = DEF_NUM_DENSE_PER_BEAT,
   parameter int unsigned COUNT_BITWIDTH     = DEF_COUNT_BITWIDTH,
   parameter int unsigned INDEX_BITWIDTH     = DEF_INDEX_BITWIDTH
) (
   input  logic                                    clock,
   input  logic                                    reset,
   input  logic                                    ivalidMask,
   output logic                                    oreadyMask,
   input  logic [BITMASK_LENGTH-1:0]               bitmask,
   input  logic                                    ivalidDense,
   output logic                                    oreadyDense,
   input  logic [ELEMENT_WIDTH*NUM_DENSE_PER_BEAT-1:0] denseInput,
   input  logic [COUNT_BITWIDTH-1:0]               numDenseInput,
   output logic                                    ovalid,
   input  logic                                    iready,
   output logic [ELEMENT_WIDTH*BITMASK_LENGTH-1:0] sparseOutput,
   output logic [BITMASK_LENGTH-1:0]               outputBitmask,
   output logic                                    oerror
);

   localparam int unsigned SUM_W = INDEX_BITWIDTH + 1;

   state_e                                  state_q, state_d;
   logic [INDEX_BITWIDTH-1:0]               consumed_q, consumed_d;
   logic [BITMASK_LENGTH-1:0]               mask_q, mask_d;
   logic [ELEMENT_WIDTH*BITMASK_LENGTH-1:0] sparse_q, sparse_d;
   logic                                    oready_mask_q, oready_mask_d;
   logic                                    oready_dense_q, oready_dense_d;
   logic                                    ovalid_q, ovalid_d;
   logic                                    oerror_q, oerror_d;

   logic [BITMASK_LENGTH*INDEX_BITWIDTH-1:0] rank_c;
   logic [INDEX_BITWIDTH-1:0]                total_c;
   logic                                     mask_fire_c;
   logic                                     dense_fire_c;
   logic                                     out_fire_c;
   logic [COUNT_BITWIDTH-1:0]                n_c;
   logic [SUM_W-1:0]                         sum_c;

   mask_prefix_counter #(
      .BITMASK_LENGTH (BITMASK_LENGTH),
      .INDEX_BITWIDTH (INDEX_BITWIDTH)
   ) u_prefix (
      .mask       (mask_q),
      .rank_c     (rank_c),
      .popcount_c (total_c)
   );

   assign mask_fire_c  = ivalidMask  & oready_mask_q;
   assign dense_fire_c = ivalidDense & oready_dense_q;
   assign out_fire_c   = ovalid_q    & iready;
   assign n_c   = (numDenseInput > COUNT_BITWIDTH'(NUM_DENSE_PER_BEAT)) ?
                  COUNT_BITWIDTH'(NUM_DENSE_PER_BEAT) : numDenseInput;
   assign sum_c = {1'b0, consumed_q} + SUM_W'(n_c);

   // Next-state, scatter and registered-output decode
   always_comb begin
      state_d    = state_q;
      consumed_d = consumed_q;
      mask_d     = mask_q;
      sparse_d   = sparse_q;
      oerror_d   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (mask_fire_c) begin
               mask_d     = bitmask;
               sparse_d   = '0;
               consumed_d = '0;
               state_d    = (bitmask == '0) ? OUTPUT : FILL;
            end
         end
         FILL: begin
            if (dense_fire_c) begin
               for (int p = 0; p < int'(BITMASK_LENGTH); p++) begin
                  for (int k = 0; k < int'(NUM_DENSE_PER_BEAT); k++) begin
                     if (mask_q[p] && (COUNT_BITWIDTH'(k) < n_c) &&
                         ({1'b0, rank_c[p*INDEX_BITWIDTH +: INDEX_BITWIDTH]} ==
                          ({1'b0, consumed_q} + SUM_W'(k)))) begin
                        sparse_d[p*ELEMENT_WIDTH +: ELEMENT_WIDTH] =
                           denseInput[k*ELEMENT_WIDTH +: ELEMENT_WIDTH];
                     end
                  end
               end
               if (sum_c > {1'b0, total_c}) begin
                  consumed_d = total_c;
                  oerror_d   = 1'b1;
               end else begin
                  consumed_d = sum_c[INDEX_BITWIDTH-1:0];
               end
               if (consumed_d == total_c) begin
                  state_d = OUTPUT;
               end
            end
         end
         OUTPUT: begin
            if (out_fire_c) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      oready_mask_d  = (state_d == IDLE);
      oready_dense_d = (state_d == FILL);
      ovalid_d       = (state_d == OUTPUT);
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= IDLE;
         consumed_q     <= '0;
         mask_q         <= '0;
         sparse_q       <= '0;
         oready_mask_q  <= 1'b0;
         oready_dense_q <= 1'b0;
         ovalid_q       <= 1'b0;
         oerror_q       <= 1'b0;
      end else begin
         state_q        <= state_d;
         consumed_q     <= consumed_d;
         mask_q         <= mask_d;
         sparse_q       <= sparse_d;
         oready_mask_q  <= oready_mask_d;
         oready_dense_q <= oready_dense_d;
         ovalid_q       <= ovalid_d;
         oerror_q       <= oerror_d;
      end
   end

   assign oreadyMask    = oready_mask_q;
   assign oreadyDense   = oready_dense_q;
   assign ovalid        = ovalid_q;
   assign oerror        = oerror_q;
   assign sparseOutput  = sparse_q;
   assign outputBitmask = mask_q;

endmodule

// File: tb/tb_sparse_expander.sv
// Directed plus randomized bench for sparse_expander against a queue-based reference model.
module tb_sparse_expander;

   localparam int unsigned BL    = 16;
   localparam int unsigned EW    = 8;
   localparam int unsigned ND    = 4;
   localparam int          LIMIT = 50;

   logic              clock = 1'b0;
   logic              reset;
   logic              ivalidMask;
   logic              oreadyMask;
   logic [BL-1:0]     bitmask;
   logic              ivalidDense;
   logic              oreadyDense;
   logic [EW*ND-1:0]  denseInput;
   logic [2:0]        numDenseInput;
   logic              ovalid;
   logic              iready;
   logic [EW*BL-1:0]  sparseOutput;
   logic [BL-1:0]     outputBitmask;
   logic              oerror;

   always #5 clock = ~clock;

   sparse_expander dut (
      .clock         (clock),
      .reset         (reset),
      .ivalidMask    (ivalidMask),
      .oreadyMask    (oreadyMask),
      .bitmask       (bitmask),
      .ivalidDense   (ivalidDense),
      .oreadyDense   (oreadyDense),
      .denseInput    (denseInput),
      .numDenseInput (numDenseInput),
      .ovalid        (ovalid),
      .iready        (iready),
      .sparseOutput  (sparseOutput),
      .outputBitmask (outputBitmask),
      .oerror        (oerror)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: positions still waiting for data, and the expected slot contents
   int            pos_q[$];
   logic [EW-1:0] exp_slot [BL];
   logic [BL-1:0] exp_mask;

   function automatic logic [EW*BL-1:0] exp_vec();
      logic [EW*BL-1:0] v;
      v = '0;
      for (int p = 0; p < int'(BL); p++) v[p*EW +: EW] = exp_slot[p];
      return v;
   endfunction

   task automatic chk_bit(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_vec(input string tag, input logic [EW*BL-1:0] obs, input logic [EW*BL-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic start_vector(input logic [BL-1:0] m);
      int waited = 0;
      exp_mask = m;
      pos_q.delete();
      for (int p = 0; p < int'(BL); p++) begin
         exp_slot[p] = '0;
         if (m[p]) pos_q.push_back(p);
      end
      ivalidMask = 1'b1;
      bitmask    = m;
      while (!oreadyMask && waited < LIMIT) begin
         @(negedge clock);
         waited++;
      end
      chk_bit("mask_ready", oreadyMask, 1'b1);
      @(negedge clock);
      ivalidMask = 1'b0;
      bitmask    = BL'($urandom);
      if (pos_q.size() == 0) begin
         chk_bit("empty_ovalid", ovalid, 1'b1);
         chk_bit("empty_no_dense_ready", oreadyDense, 1'b0);
      end else begin
         chk_bit("fill_dense_ready", oreadyDense, 1'b1);
         chk_bit("fill_ovalid_low", ovalid, 1'b0);
      end
   endtask

   task automatic send_beat(input logic [EW*ND-1:0] data, input int n);
      int   waited = 0;
      int   eff;
      logic err = 1'b0;
      ivalidDense   = 1'b1;
      denseInput    = data;
      numDenseInput = 3'(n);
      while (!oreadyDense && waited < LIMIT) begin
         @(negedge clock);
         waited++;
      end
      chk_bit("dense_ready", oreadyDense, 1'b1);
      @(negedge clock);
      ivalidDense   = 1'b0;
      denseInput    = (EW*ND)'($urandom);
      numDenseInput = 3'($urandom);
      eff = (n > int'(ND)) ? int'(ND) : n;
      for (int k = 0; k < eff; k++) begin
         if (pos_q.size() > 0) exp_slot[pos_q.pop_front()] = data[k*EW +: EW];
         else err = 1'b1;
      end
      chk_bit("oerror_after_beat", oerror, err);
      chk_bit("ovalid_after_beat", ovalid, pos_q.size() == 0);
   endtask

   task automatic finish_vector(input int stall);
      chk_bit("ovalid", ovalid, 1'b1);
      chk_vec("sparse", sparseOutput, exp_vec());
      chk_vec("out_mask", (EW*BL)'(outputBitmask), (EW*BL)'(exp_mask));
      for (int i = 0; i < stall; i++) begin
         iready = 1'b0;
         @(negedge clock);
         chk_bit("stall_ovalid", ovalid, 1'b1);
         chk_vec("stall_sparse", sparseOutput, exp_vec());
         chk_bit("stall_no_dense_ready", oreadyDense, 1'b0);
      end
      iready = 1'b1;
      @(negedge clock);
      iready = 1'b0;
      chk_bit("accepted_ovalid_low", ovalid, 1'b0);
      chk_bit("accepted_mask_ready", oreadyMask, 1'b1);
      chk_bit("accepted_oerror_low", oerror, 1'b0);
   endtask

   initial begin
      logic [EW*ND-1:0] d;
      logic [BL-1:0]    m;
      int               r;
      int               guard;

      reset         = 1'b1;
      ivalidMask    = 1'b0;
      bitmask       = '0;
      ivalidDense   = 1'b0;
      denseInput    = '0;
      numDenseInput = '0;
      iready        = 1'b0;
      for (int p = 0; p < int'(BL); p++) exp_slot[p] = '0;
      exp_mask = '0;

      repeat (2) @(negedge clock);
      chk_bit("rst_oreadyMask", oreadyMask, 1'b0);
      chk_bit("rst_oreadyDense", oreadyDense, 1'b0);
      chk_bit("rst_ovalid", ovalid, 1'b0);
      chk_bit("rst_oerror", oerror, 1'b0);
      chk_vec("rst_sparse", sparseOutput, '0);
      chk_vec("rst_mask", (EW*BL)'(outputBitmask), '0);
      reset = 1'b0;
      @(negedge clock);
      chk_bit("post_rst_oreadyMask", oreadyMask, 1'b1);

      // All-zero mask goes straight to output
      start_vector(16'h0000);
      finish_vector(0);

      // Dense beat while idle must be ignored
      ivalidDense   = 1'b1;
      denseInput    = 32'hDEAD_BEEF;
      numDenseInput = 3'd4;
      @(negedge clock);
      ivalidDense   = 1'b0;
      chk_bit("idle_dense_ignored", oreadyMask, 1'b1);

      start_vector(16'h8001);
      d = 32'h0000_2211;
      send_beat(d, 2);
      finish_vector(1);

      start_vector(16'hFFFF);
      for (int b = 0; b < 4; b++) begin
         for (int k = 0; k < int'(ND); k++) d[k*EW +: EW] = EW'(b*4 + k + 1);
         send_beat(d, 4);
      end
      finish_vector(5);

      start_vector(16'h00F0);
      send_beat(EW*ND'($urandom), 3);
      send_beat(EW*ND'($urandom), 3);
      finish_vector(0);

      start_vector(16'h0300);
      send_beat(EW*ND'($urandom), 0);
      d = 32'h0000_0B0A;
      send_beat(d, 2);
      finish_vector(0);

      // Reset in the middle of a fill drops the partial vector
      start_vector(16'hFFFF);
      send_beat(EW*ND'($urandom), 4);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk_bit("midrst_ovalid", ovalid, 1'b0);
      chk_bit("midrst_oreadyDense", oreadyDense, 1'b0);
      chk_vec("midrst_sparse", sparseOutput, '0);
      @(negedge clock);
      chk_bit("midrst_oreadyMask", oreadyMask, 1'b1);
      start_vector(16'h0001);
      d = 32'h0000_0005;
      send_beat(d, 1);
      finish_vector(0);

      // Randomized masks, beat sizes (including oversize counts) and stalls
      for (int v = 0; v < 40; v++) begin
         m = BL'($urandom);
         r = $urandom_range(0, 9);
         if (r < 3) m = m & BL'($urandom);
         else if (r == 3) m = '0;
         else if (r == 4) m = '1;
         start_vector(m);
         guard = 0;
         while (pos_q.size() > 0 && guard < 40) begin
            r = $urandom_range(0, 9);
            send_beat(EW*ND'($urandom), (r < 8) ? (r % 5) : (r - 3));
            guard++;
         end
         finish_vector($urandom_range(0, 3));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
